// File: rtl/cpa_trace_sequencer.sv
// Campaign controller: LFSR plaintexts -> link send -> wait ciphertext -> record, with scope trigger.
// Optional CPA_TVLA_INTERLEAVE_EN: even traces send FIXED_PT (LFSR held), odd traces use the LFSR.
module cpa_trace_sequencer #(
    parameter int unsigned  N_TRACES   = 1000,
    parameter int unsigned  TIMEOUT    = 1000000,
    parameter int unsigned  GAP_CYCLES = 64,
    parameter int unsigned  TRIG_LEN   = 16,
    parameter logic [127:0] SEED       = 128'h0123456789abcdeffedcba9876543210,
    parameter logic [127:0] FIXED_PT   = 128'h0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    output logic [127:0] tx_data_o,
    output logic         cmd_send_o,
    input  logic [127:0] rx_data_i,
    input  logic         receive_ok_i,
    output logic         trig_o,
    output logic         rec_valid_o,
    output logic [127:0] pt_out_o,
    output logic [127:0] ct_out_o,
    output logic [15:0]  trace_cnt_o,
    output logic [15:0]  timeout_cnt_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SEND, S_WAIT, S_LOG, S_GAP, S_DONE
    } state_e;

    localparam logic [127:0] SEED_EFF  = (SEED == 128'd0) ? 128'd1 : SEED;
    localparam logic [31:0]  GEN_LAST  = 32'd127;
    localparam logic [31:0]  TO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [31:0]  GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]  TRIG_LOAD = 32'(TRIG_LEN - 1);
    localparam logic [15:0]  N_LAST    = 16'(N_TRACES);

    function automatic logic [127:0] lfsr_step(input logic [127:0] l);
        return {l[126:0], l[127] ^ l[125] ^ l[100] ^ l[98]};
    endfunction

    state_e       state_q, state_d;
    logic [31:0]  timer_q, timer_d;
    logic [31:0]  trig_cnt_q, trig_cnt_d;
    logic [127:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [127:0] tx_q, tx_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    logic [15:0]  trace_q, trace_d;
    logic [15:0]  tocnt_q, tocnt_d;
    logic         busy, use_fixed, kill;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            trig_cnt_q <= '0;
            lfsr_q     <= SEED_EFF;
            tx_q       <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            trace_q    <= '0;
            tocnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            trig_cnt_q <= trig_cnt_d;
            lfsr_q     <= lfsr_d;
            tx_q       <= tx_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
            trace_q    <= trace_d;
            tocnt_q    <= tocnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        trig_cnt_d = (trig_cnt_q != 32'd0) ? trig_cnt_q - 32'd1 : 32'd0;
        lfsr_d     = lfsr_q;
        tx_d       = tx_q;
        pt_d       = pt_q;
        ct_d       = ct_q;
        trace_d    = trace_q;
        tocnt_d    = tocnt_q;
        cmd_send_o = 1'b0;
        rec_valid_o = 1'b0;
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        kill       = busy && abort_i;
`ifdef CPA_TVLA_INTERLEAVE_EN
        use_fixed  = ~trace_q[0];
`else
        use_fixed  = 1'b0;
`endif
        lfsr_nxt   = use_fixed ? lfsr_q : lfsr_step(lfsr_q);

        // abort outranks every other event, but counters and records are kept
        if (kill) begin
            state_d    = S_IDLE;
            trig_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        trace_d = '0;
                        tocnt_d = '0;
                        lfsr_d  = SEED_EFF;
                        timer_d = '0;
                        state_d = S_GEN;
                    end
                end
                S_GEN: begin
                    lfsr_d = lfsr_nxt;
                    if (timer_q == GEN_LAST) begin
                        tx_d    = use_fixed ? FIXED_PT : lfsr_nxt;
                        timer_d = '0;
                        state_d = S_SEND;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                S_SEND: begin
                    cmd_send_o = 1'b1;
                    timer_d    = '0;
                    trig_cnt_d = TRIG_LOAD;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (receive_ok_i) begin
                        ct_d    = rx_data_i;
                        pt_d    = tx_q;
                        timer_d = '0;
                        state_d = S_LOG;
                    end else if (timer_q == TO_LAST) begin
                        tocnt_d = (tocnt_q == 16'hFFFF) ? tocnt_q : tocnt_q + 16'd1;
                        trace_d = trace_q + 16'd1;
                        timer_d = '0;
                        state_d = S_GAP;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                S_LOG: begin
                    rec_valid_o = 1'b1;
                    trace_d     = trace_q + 16'd1;
                    timer_d     = '0;
                    state_d     = S_GAP;
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_d = '0;
                        state_d = (trace_q == N_LAST) ? S_DONE : S_GEN;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign trig_o        = ((state_q == S_SEND) || (trig_cnt_q != 32'd0)) && !kill;
    assign tx_data_o     = tx_q;
    assign pt_out_o      = pt_q;
    assign ct_out_o      = ct_q;
    assign trace_cnt_o   = trace_q;
    assign timeout_cnt_o = tocnt_q;
    assign busy_o        = busy;
    assign done_o        = (state_q == S_DONE);

endmodule

// File: doc/cpa_trace_sequencer.md
# cpa_trace_sequencer

FPGA1-side campaign controller that drives the AES target on FPGA2 across the byte link. It generates a stream of 128-bit plaintexts from an internal LFSR and issues one send command per trace. It waits for the returned ciphertext, pulses a scope trigger aligned to each send, and emits a (plaintext, ciphertext) record for logging. It sits directly upstream of the FPGA1 link endpoint and consumes that endpoint's receive path.

## Interface
- N_TRACES, 1000: traces per campaign, 1..65535.
- TIMEOUT, 1000000: cycles to wait for ciphertext after a send, ≥2.
- GAP_CYCLES, 64: idle cycles between traces so FPGA2 returns to its idle state, ≥1.
- TRIG_LEN, 16: scope-trigger width in cycles, ≥1.
- SEED, 128'h0123456789abcdeffedcba9876543210: LFSR seed. An all-zero SEED is replaced by 128'd1.
- FIXED_PT, 128'h0: fixed plaintext, used only under the macro.
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset. Synchronous, active-low.
- start  in  1  one-cycle request to begin a campaign.
- abort  in  1  stop the campaign and return to IDLE.
- tx_data  out  128  plaintext presented to the link.
- cmd_send  out  1  one-cycle send strobe to the link.
- rx_data  in  128  ciphertext from the link.
- receive_ok  in  1  one-cycle strobe; rx_data is valid this cycle.
- trig  out  1  scope trigger.
- rec_valid  out  1  one-cycle record strobe.
- pt_out, ct_out  out  128 each  record contents.
- trace_cnt  out  16  traces completed, including timed-out traces.
- timeout_cnt  out  16  traces that timed out.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  campaign complete.

## Operation
- States: IDLE, GEN, SEND, WAIT, LOG, GAP, DONE.
- Reset (rst=0): state=IDLE. All outputs are 0 after reset. lfsr=SEED (with the zero substitution); timer=0.
- IDLE / DONE, on start:
  - trace_cnt=0, timeout_cnt=0, lfsr reloaded from SEED.
  - done is cleared and the state moves to GEN.
  - In DONE, done is held at 1 until start arrives.
- GEN:
  - Runs 128 cycles. Each cycle applies one Fibonacci step: lfsr <= {lfsr[126:0], lfsr[127]^lfsr[125]^lfsr[100]^lfsr[98]}.
  - On the last cycle, tx_data <= next lfsr value, then the state moves to SEND.
- SEND:
  - cmd_send=1 for this single cycle, timer=0.
  - trig rises and stays high for TRIG_LEN cycles, counted by an independent counter.
  - Next state is WAIT.
- WAIT:
  - On receive_ok: ct_out <= rx_data, pt_out <= tx_data, then LOG.
  - Otherwise timer increments. When timer reaches TIMEOUT-1, timeout_cnt increments (saturating at 16'hFFFF) and the state moves to GAP with no record emitted; trace_cnt still increments.
- LOG: rec_valid=1 for one cycle, trace_cnt increments, then GAP.
- GAP:
  - Waits GAP_CYCLES cycles.
  - Then goes to DONE if trace_cnt==N_TRACES, otherwise to GEN.
- receive_ok arriving in any state other than WAIT is ignored.
- abort takes effect in any busy state: the next state is IDLE and cmd_send, trig and rec_valid are forced to 0. Counters and pt_out/ct_out are retained. abort has priority over start and receive_ok in the same cycle.
- start arriving while busy is ignored.

## Timing
- start is sampled at cycle 0. GEN occupies cycles 1–128, cmd_send is high at cycle 129 and trig is high for cycles 129 to 129+TRIG_LEN-1.
- tx_data changes only on the last GEN cycle. It is stable from cmd_send through the end of LOG/GAP.
- receive_ok sampled at cycle k in WAIT gives rec_valid at cycle k+1.
- Trace period is 128 + 1 + (wait cycles) + 1 + GAP_CYCLES.
- Timeout: with no receive_ok, WAIT lasts exactly TIMEOUT cycles.
- Reset asserted mid-campaign returns the block to its reset state on the next edge.

## Configuration
- CPA_TVLA_INTERLEAVE_EN defined:
  - Traces with an even trace_cnt use FIXED_PT and the LFSR is not advanced: GEN still takes 128 cycles but lfsr is held.
  - Traces with an odd trace_cnt use the LFSR as above.
- CPA_TVLA_INTERLEAVE_EN undefined: every trace uses the LFSR and FIXED_PT is unused.

## Test plan
- Reset: hold rst=0 for 5 cycles → all outputs 0 and state=IDLE. Release rst and do not pulse start → cmd_send stays 0 for 1000 cycles.
- Nominal campaign: N_TRACES=3, GAP_CYCLES=8, link model returns rx_data=~tx_data with receive_ok 40 cycles after cmd_send → 3 rec_valid pulses with ct_out==~pt_out, consecutive pt_out match a software LFSR model, done=1, trace_cnt=3, timeout_cnt=0.
- Timeout: TIMEOUT=100, link never responds, N_TRACES=2 → no rec_valid; timeout_cnt=2, trace_cnt=2 and done=1. Each WAIT lasts exactly 100 cycles.
- Abort and strobe filtering:
  - Assert abort in the cycle receive_ok arrives during trace 2 → no rec_valid for trace 2, IDLE next cycle, trace_cnt=1.
  - A stray receive_ok during GAP is ignored.
- Trigger alignment: TRIG_LEN=16 → trig rises in the same cycle as cmd_send and is high for exactly 16 cycles on every trace.
- With CPA_TVLA_INTERLEAVE_EN, FIXED_PT=128'hAA…AA, N_TRACES=4 → pt_out sequence is AA…AA, R1, AA…AA, R2, where R1 and R2 are the first two LFSR outputs.
